// File: rtl/regc_byte_tx.sv
// Transmit side of the 16-bit C result register: captures a word on ld and
// sends it as two bytes over a valid/ready interface, reporting completion.
module regc_byte_tx #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ld,
  input  logic [15:0] din,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        ld_err,
  output logic [7:0]  word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_shadow;
  logic [7:0]  r_dout;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_ld_err;
  logic [7:0]  r_cnt;

  logic        w_xfer;
  logic        w_capture;
  logic        w_in_send;
  logic [7:0]  w_dout_nxt;
  logic        w_valid_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_ld_err_nxt;
  logic [7:0]  w_cnt_nxt;

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return MSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return MSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  assign w_xfer    = r_valid & dout_ready;
  assign w_in_send = (r_state == SEND0) || (r_state == SEND1);
  // DONE accepts a new word exactly like IDLE, giving a 3-cycle word period
  assign w_capture = ld & ((r_state == IDLE) || (r_state == DONE));

  // State and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= IDLE;
      r_shadow <= 16'h0000;
      r_dout   <= 8'h00;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ld_err <= 1'b0;
      r_cnt    <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      if (w_capture)
        r_shadow <= din;
      r_dout   <= w_dout_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_ld_err <= w_ld_err_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: w_state_nxt = ld ? SEND0 : IDLE;
      SEND0:      if (w_xfer) w_state_nxt = SEND1;
      SEND1:      if (w_xfer) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_dout_nxt   = r_dout;
    w_cnt_nxt    = r_cnt;
    w_ld_err_nxt = ld & w_in_send;
    w_valid_nxt  = (w_state_nxt == SEND0) || (w_state_nxt == SEND1);
    w_busy_nxt   = w_valid_nxt;
    w_done_nxt   = (w_state_nxt == DONE);
    if (w_capture)
      w_dout_nxt = first_byte(din);
    else if ((r_state == SEND0) && w_xfer)
      w_dout_nxt = second_byte(r_shadow);
    if ((r_state == SEND1) && w_xfer)
      w_cnt_nxt = r_cnt + 8'd1;
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ld_err     = r_ld_err;
  assign word_cnt   = r_cnt;

endmodule
